regfile_read_port: RTL and testbench
====================================

REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NREG, default 16, number of registers; ADDR_W = log2(NREG) = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  read request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_src1  input  ADDR_W  port-1 source register.
REQ-008 SHALL have port req_src2  input  ADDR_W  port-2 source register.
REQ-009 SHALL have port ReadEnable1  output  NREG  one-hot port-1 read enables to the register array.
REQ-010 SHALL have port ReadEnable2  output  NREG  one-hot port-2 read enables to the register array.
REQ-011 SHALL have port Bitline1  input  DATA_W  port-1 bitlines driven by the enabled register.
REQ-012 SHALL have port Bitline2  input  DATA_W  port-2 bitlines driven by the enabled register.
REQ-013 SHALL have port wr_en  input  1  same-cycle register write in progress (bypass source).
REQ-014 SHALL have port wr_reg  input  ADDR_W  register being written.
REQ-015 SHALL have port wr_data  input  DATA_W  data being written.
REQ-016 SHALL have port rsp_valid  output  1  read data available.
REQ-017 SHALL have port rsp_ready  input  1  consumer accepts read data.
REQ-018 SHALL have ports rsp_data1 and rsp_data2  output  DATA_W each  read results for src1 and src2.

Function
REQ-019 SHALL implement FSM states IDLE, READ, RESP.
REQ-020 IDLE: req_ready=1; on req_valid&&req_ready, latch src1/src2 and go to READ; otherwise stay.
REQ-021 READ (exactly one cycle): ReadEnable1/2 = registered one-hot of latched src1/src2; all other bits 0; at the closing edge capture Bitline1/2 into rsp_data1/2 and go to RESP.
REQ-022 ReadEnable1/2 SHALL be all-zero in IDLE and RESP; never more than one bit set per port.
REQ-023 Bypass: in READ, if wr_en=1 and wr_reg equals a latched source, that port SHALL capture wr_data instead of its bitlines; both ports bypass independently when both match.
REQ-024 Register 0: a source of 0 SHALL return all-zero data, with no bypass and no read enable asserted for that port.
REQ-025 RESP: rsp_valid=1 and rsp_data1/2 stable until rsp_valid&&rsp_ready; then go to IDLE in the next cycle.
REQ-026 Writes during RESP SHALL NOT alter held rsp_data; data reflects the READ-cycle snapshot.
REQ-027 Latency: request accepted at edge N -> enables high during cycle N+1 -> rsp_valid high after edge N+2; throughput one request per 3 cycles minimum.
REQ-028 req_ready SHALL be 0 in READ and RESP; requests presented then are not accepted and must be held by the requester.
REQ-029 src1 == src2 SHALL be legal; both enables carry the same bit set and both outputs carry equal data.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, ReadEnable1/2=0, rsp_valid=0, rsp_data1/2=0, latched sources=0; req_ready=1 after release.
REQ-031 Reset asserted in READ or RESP SHALL discard the in-flight request with no response issued.

Structure
REQ-032 Package regfile_pkg SHALL hold DATA_W, NREG, ADDR_W defaults and the FSM state enum.
REQ-033 A sub-module read_decoder (ADDR_W -> NREG one-hot with enable input) SHALL be instantiated once per port.

Verification
REQ-034 Preload R3=0x1234, R7=0xBEEF; request src1=3, src2=7 -> ReadEnable1=0x0008, ReadEnable2=0x0080 for one cycle; rsp_data1=0x1234, rsp_data2=0xBEEF, 2 cycles after accept.
REQ-035 Request src1=5, src2=5 with wr_en=1, wr_reg=5, wr_data=0xA5A5 in the READ cycle -> both outputs 0xA5A5.
REQ-036 Request src1=0, src2=9 (R9=0x0042) -> ReadEnable1=0, rsp_data1=0x0000, rsp_data2=0x0042.
REQ-037 Hold rsp_ready=0 for 5 cycles while writing R3=0xFFFF -> rsp_valid stays 1, data unchanged, req_ready=0 throughout; accept on cycle 6 -> IDLE.
REQ-038 Assert rst during READ -> enables drop to 0 immediately, no rsp_valid follows, next request completes normally.
REQ-039 Back-to-back req_valid held high with rsp_ready=1 -> exactly one accept every 3 cycles; enables never multi-hot.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM encoding for the register-file read port.
package regfile_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_NREG   = 16;
    localparam int RF_ADDR_W = $clog2(RF_NREG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/read_decoder.sv
// Address to one-hot read-enable decoder; output is all-zero when disabled.
module read_decoder #(
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREG-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            o_onehot[i] = i_en && (i_addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Two-port register-file read sequencer: IDLE -> READ (enables driven) -> RESP,
// with same-cycle write bypass and a hard-wired zero register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int NREG   = RF_NREG,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    output logic [NREG-1:0]   ReadEnable1,
    output logic [NREG-1:0]   ReadEnable2,
    input  logic [DATA_W-1:0] Bitline1,
    input  logic [DATA_W-1:0] Bitline2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_src1;
    logic [ADDR_W-1:0]   r_src2;
    logic [NREG-1:0]     r_re1;
    logic [NREG-1:0]     r_re2;
    logic [NREG-1:0]     w_dec1;
    logic [NREG-1:0]     w_dec2;
    logic [DATA_W-1:0]   r_data1;
    logic [DATA_W-1:0]   r_data2;
    logic [DATA_W-1:0]   w_cap1;
    logic [DATA_W-1:0]   w_cap2;
    logic                w_accept;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // Decoding the incoming address at accept lets the enables come straight
    // from a register during the READ cycle; they clear on the following edge.
    read_decoder #(.ADDR_W(ADDR_W), .NREG(NREG)) u_dec1 (
        .i_en     (w_accept && (req_src1 != '0)),
        .i_addr   (req_src1),
        .o_onehot (w_dec1)
    );

    read_decoder #(.ADDR_W(ADDR_W), .NREG(NREG)) u_dec2 (
        .i_en     (w_accept && (req_src2 != '0)),
        .i_addr   (req_src2),
        .o_onehot (w_dec2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_READ;
            ST_READ: w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Register 0 reads as zero and is never a bypass target.
    always_comb begin
        w_cap1 = Bitline1;
        w_cap2 = Bitline2;
        if (r_src1 == '0) begin
            w_cap1 = '0;
        end else if (wr_en && (wr_reg == r_src1)) begin
            w_cap1 = wr_data;
        end
        if (r_src2 == '0) begin
            w_cap2 = '0;
        end else if (wr_en && (wr_reg == r_src2)) begin
            w_cap2 = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src1  <= '0;
            r_src2  <= '0;
            r_re1   <= '0;
            r_re2   <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_re1 <= w_dec1;
            r_re2 <= w_dec2;
            if (w_accept) begin
                r_src1 <= req_src1;
                r_src2 <= req_src2;
            end
            if (r_state == ST_READ) begin
                r_data1 <= w_cap1;
                r_data2 <= w_cap2;
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign ReadEnable1 = r_re1;
    assign ReadEnable2 = r_re2;
    assign rsp_data1   = r_data1;
    assign rsp_data2   = r_data2;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port with a behavioural register array model.
module tb_regfile_read_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src1;
    logic [3:0]  req_src2;
    logic [15:0] ReadEnable1;
    logic [15:0] ReadEnable2;
    logic [15:0] Bitline1;
    logic [15:0] Bitline2;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data1;
    logic [15:0] rsp_data2;

    int checks = 0;
    int errors = 0;

    logic [15:0] regs [16];

    regfile_read_port #(.DATA_W(16), .NREG(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .ReadEnable1 (ReadEnable1),
        .ReadEnable2 (ReadEnable2),
        .Bitline1    (Bitline1),
        .Bitline2    (Bitline2),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data1   (rsp_data1),
        .rsp_data2   (rsp_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) regs[wr_reg] <= wr_data;
    end

    // Bitlines are the OR of every enabled register, so a multi-hot or stray
    // enable corrupts the read data.
    always_comb begin
        Bitline1 = '0;
        Bitline2 = '0;
        for (int i = 0; i < 16; i++) begin
            if (ReadEnable1[i]) Bitline1 = Bitline1 | regs[i];
            if (ReadEnable2[i]) Bitline2 = Bitline2 | regs[i];
        end
    end

    task automatic write_reg(input logic [3:0] r, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge inside the READ cycle.
    task automatic start_req(input logic [3:0] s1, input logic [3:0] s2);
        @(negedge clk);
        req_valid = 1'b1; req_src1 = s1; req_src2 = s2;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_resp(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_return_idle: got valid=%b ready=%b expected valid=0 ready=1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_enables: got %h/%h expected 0000/0000", ReadEnable1, ReadEnable2);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data1 !== 16'h0 || rsp_data2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b d1=%h d2=%h expected 0/0000/0000", rsp_valid, rsp_data1, rsp_data2);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_basic_read;
        start_req(4'd3, 4'd7);
        checks++;
        if (ReadEnable1 !== 16'h0008 || ReadEnable2 !== 16'h0080) begin
            errors++;
            $display("FAIL basic_enables: got %h/%h expected 0008/0080", ReadEnable1, ReadEnable2);
        end
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_read_ctrl: got ready=%b valid=%b expected 0/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) begin
            errors++;
            $display("FAIL basic_enables_drop: got %h/%h expected 0000/0000", ReadEnable1, ReadEnable2);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data1 !== 16'h1234 || rsp_data2 !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_data: got valid=%b d1=%h d2=%h expected 1/1234/beef", rsp_valid, rsp_data1, rsp_data2);
        end
        finish_resp("basic");
    endtask

    task automatic test_bypass;
        start_req(4'd5, 4'd5);
        wr_en = 1'b1; wr_reg = 4'd5; wr_data = 16'hA5A5;
        checks++;
        if (ReadEnable1 !== 16'h0020 || ReadEnable2 !== 16'h0020) begin
            errors++;
            $display("FAIL bypass_same_src_enables: got %h/%h expected 0020/0020", ReadEnable1, ReadEnable2);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (rsp_data1 !== 16'hA5A5 || rsp_data2 !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_both: got %h/%h expected a5a5/a5a5", rsp_data1, rsp_data2);
        end
        finish_resp("bypass_both");

        start_req(4'd3, 4'd7);
        wr_en = 1'b1; wr_reg = 4'd7; wr_data = 16'h7777;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (rsp_data1 !== 16'h1234 || rsp_data2 !== 16'h7777) begin
            errors++;
            $display("FAIL bypass_port2_only: got %h/%h expected 1234/7777", rsp_data1, rsp_data2);
        end
        finish_resp("bypass_port2");
    endtask

    task automatic test_reg0;
        start_req(4'd0, 4'd9);
        wr_en = 1'b1; wr_reg = 4'd0; wr_data = 16'hDEAD;
        checks++;
        if (ReadEnable1 !== 16'h0000 || ReadEnable2 !== 16'h0200) begin
            errors++;
            $display("FAIL reg0_enables: got %h/%h expected 0000/0200", ReadEnable1, ReadEnable2);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (rsp_data1 !== 16'h0000 || rsp_data2 !== 16'h0042) begin
            errors++;
            $display("FAIL reg0_data: got %h/%h expected 0000/0042", rsp_data1, rsp_data2);
        end
        finish_resp("reg0");
    endtask

    task automatic test_hold;
        start_req(4'd3, 4'd9);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wr_en = 1'b1; wr_reg = 4'd3; wr_data = 16'hFFFF;
            req_valid = 1'b1; req_src1 = 4'd1; req_src2 = 4'd2;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data1 !== 16'h1234 || rsp_data2 !== 16'h0042) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b d1=%h d2=%h expected 1/0/1234/0042", c, rsp_valid, req_ready, rsp_data1, rsp_data2);
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data1 !== 16'h1234) begin
            errors++;
            $display("FAIL hold_final: got valid=%b d1=%h expected 1/1234", rsp_valid, rsp_data1);
        end
        finish_resp("hold");
    endtask

    task automatic test_reset_mid_read;
        start_req(4'd3, 4'd9);
        checks++;
        if (ReadEnable1 !== 16'h0008) begin
            errors++;
            $display("FAIL rstmid_pre: got %h expected 0008", ReadEnable1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got %h/%h valid=%b expected 0000/0000/0", ReadEnable1, ReadEnable2, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_no_rsp%0d: got valid=%b ready=%b expected 0/1", c, rsp_valid, req_ready);
            end
        end
        start_req(4'd9, 4'd3);
        checks++;
        if (ReadEnable1 !== 16'h0200 || ReadEnable2 !== 16'h0008) begin
            errors++;
            $display("FAIL rstmid_next_enables: got %h/%h expected 0200/0008", ReadEnable1, ReadEnable2);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data1 !== 16'h0042 || rsp_data2 !== 16'hFFFF) begin
            errors++;
            $display("FAIL rstmid_next_data: got valid=%b d1=%h d2=%h expected 1/0042/ffff", rsp_valid, rsp_data1, rsp_data2);
        end
        finish_resp("rstmid");
    endtask

    task automatic test_back_to_back;
        int accepts;
        int last;
        int bad_gap;
        int multi;
        accepts = 0; last = -1; bad_gap = 0; multi = 0;
        @(negedge clk);
        req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd9; rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready === 1'b1) begin
                if (last >= 0 && (c - last) != 3) bad_gap++;
                last = c;
                accepts++;
            end
            if ($countones(ReadEnable1) > 1 || $countones(ReadEnable2) > 1) multi++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (accepts != 4 || bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts, %0d bad gaps expected 4 accepts, 0 bad gaps", accepts, bad_gap);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL b2b_onehot: got %0d multi-hot cycles expected 0", multi);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_src1 = '0; req_src2 = '0;
        wr_en = 1'b0; wr_reg = '0; wr_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        test_reset;
        write_reg(4'd3, 16'h1234);
        write_reg(4'd7, 16'hBEEF);
        write_reg(4'd5, 16'h5555);
        write_reg(4'd9, 16'h0042);
        test_basic_read;
        test_bypass;
        test_reg0;
        test_hold;
        test_reset_mid_read;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
